// File: rtl/sprite_mover.sv
// sprite_mover: frame-rate movement controller for one maze sprite.
//   Per step tick, a queued turn is applied first (reversal at any time,
//   other turns only on grid points with an open path), then the sprite
//   moves STEP pixels in its post-turn facing if the path is open and the
//   centre stays inside [MIN+SIZE, MAX-SIZE].
// Ports:
//   frame_clk    frame clock (one edge per video frame)
//   Reset_n      synchronous active-low reset
//   playon       1 = game running, 0 = hold sprite at spawn
//   keycode      04 left, 07 right, 16 down, 1A up; others ignored
//   wall_free    per-direction path-open flags, indexed by direction code
//   BallX/BallY  sprite centre;  BallS = SIZE
//   whichside    facing: 0 left, 1 right, 2 down, 3 up
//   moving       FSM in MOVING;  turn_pending  a queued direction is held
module sprite_mover #(
  parameter int X_CENTER  = 310,
  parameter int Y_CENTER  = 260,
  parameter int X_MIN     = 30,
  parameter int X_MAX     = 590,
  parameter int Y_MIN     = 30,
  parameter int Y_MAX     = 430,
  parameter int SIZE      = 4,
  parameter int STEP      = 1,
  parameter int TILE      = 10,
  parameter int SPEED_DIV = 1
) (
  input  logic       frame_clk,
  input  logic       Reset_n,
  input  logic       playon,
  input  logic [7:0] keycode,
  input  logic [3:0] wall_free,
  output logic [9:0] BallX,
  output logic [9:0] BallY,
  output logic [9:0] BallS,
  output logic [1:0] whichside,
  output logic       moving,
  output logic       turn_pending
);

  localparam logic [9:0] XC   = 10'(X_CENTER);
  localparam logic [9:0] YC   = 10'(Y_CENTER);
  localparam logic [9:0] XLO  = 10'(X_MIN + SIZE);
  localparam logic [9:0] XHI  = 10'(X_MAX - SIZE);
  localparam logic [9:0] YLO  = 10'(Y_MIN + SIZE);
  localparam logic [9:0] YHI  = 10'(Y_MAX - SIZE);
  localparam logic [9:0] STP  = 10'(STEP);
  localparam logic [9:0] TSTP = 10'(TILE - STEP);
  localparam logic [7:0] CMAX = 8'(SPEED_DIV - 1);

  localparam logic [1:0] D_L = 2'd0, D_R = 2'd1, D_D = 2'd2, D_U = 2'd3;

  typedef enum logic [1:0] {HOLD, STOPPED, MOVING} state_t;

  state_t     state_q, state_d;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic [9:0] xph_q, xph_d, yph_q, yph_d;
  logic [1:0] side_q, side_d, pdir_q, pdir_d;
  logic       pend_q, pend_d;
  logic [7:0] cnt_q, cnt_d;

  logic       key_vld, tick, aligned, pend_eff, turn_ok, in_bounds, can_move;
  logic [1:0] key_dir, pdir_eff, dir_n;

  // Tile phase walks with the position so grid alignment needs no modulo.
  function automatic logic [9:0] ph_inc(input logic [9:0] ph);
    return (ph == TSTP) ? 10'd0 : ph + STP;
  endfunction

  function automatic logic [9:0] ph_dec(input logic [9:0] ph);
    return (ph == 10'd0) ? TSTP : ph - STP;
  endfunction

  always_comb begin
    key_vld = 1'b1;
    key_dir = D_L;
    case (keycode)
      8'h04:   key_dir = D_L;
      8'h07:   key_dir = D_R;
      8'h16:   key_dir = D_D;
      8'h1A:   key_dir = D_U;
      default: key_vld = 1'b0;
    endcase
  end

  // A key arriving on a tick edge takes part in that tick's turn decision.
  assign tick     = (cnt_q == CMAX);
  assign aligned  = (xph_q == 10'd0) && (yph_q == 10'd0);
  assign pend_eff = pend_q | key_vld;
  assign pdir_eff = key_vld ? key_dir : pdir_q;
  // Direction codes pair up as {L,R} and {D,U}: reverse is bit 0 flipped.
  assign turn_ok  = tick && pend_eff &&
                    ((pdir_eff == (side_q ^ 2'b01)) || (aligned && wall_free[pdir_eff]));
  assign dir_n    = turn_ok ? pdir_eff : side_q;

  // Bound test is done before the update so 10-bit arithmetic never wraps.
  always_comb begin
    in_bounds = 1'b0;
    case (dir_n)
      D_L: in_bounds = (x_q >= XLO + STP);
      D_R: in_bounds = (x_q + STP <= XHI);
      D_D: in_bounds = (y_q + STP <= YHI);
      D_U: in_bounds = (y_q >= YLO + STP);
    endcase
  end

  assign can_move = wall_free[dir_n] && in_bounds;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    xph_d   = xph_q;
    yph_d   = yph_q;
    side_d  = side_q;
    pdir_d  = pdir_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    if (!playon) begin
      state_d = HOLD;
      x_d     = XC;
      y_d     = YC;
      xph_d   = 10'd0;
      yph_d   = 10'd0;
      side_d  = D_L;
      pdir_d  = D_L;
      pend_d  = 1'b0;
      cnt_d   = 8'd0;
    end else if (state_q == HOLD) begin
      state_d = STOPPED;
    end else begin
      pend_d = pend_eff;
      pdir_d = pdir_eff;
      cnt_d  = tick ? 8'd0 : cnt_q + 8'd1;
      if (turn_ok) begin
        side_d = dir_n;
        pend_d = 1'b0;
      end
      // A stopped sprite only restarts when a turn is applied on this tick.
      if (tick && (state_q == MOVING || turn_ok)) begin
        if (can_move) begin
          state_d = MOVING;
          case (dir_n)
            D_L: begin x_d = x_q - STP; xph_d = ph_dec(xph_q); end
            D_R: begin x_d = x_q + STP; xph_d = ph_inc(xph_q); end
            D_D: begin y_d = y_q + STP; yph_d = ph_inc(yph_q); end
            D_U: begin y_d = y_q - STP; yph_d = ph_dec(yph_q); end
          endcase
        end else begin
          state_d = STOPPED;
        end
      end
    end
  end

  always_ff @(posedge frame_clk) begin
    if (!Reset_n) begin
      state_q <= HOLD;
      x_q     <= XC;
      y_q     <= YC;
      xph_q   <= 10'd0;
      yph_q   <= 10'd0;
      side_q  <= D_L;
      pdir_q  <= D_L;
      pend_q  <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      xph_q   <= xph_d;
      yph_q   <= yph_d;
      side_q  <= side_d;
      pdir_q  <= pdir_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
    end
  end

  assign BallX        = x_q;
  assign BallY        = y_q;
  assign BallS        = 10'(SIZE);
  assign whichside    = side_q;
  assign moving       = (state_q == MOVING);
  assign turn_pending = pend_q;

endmodule

// File: tb/tb_sprite_mover.sv
module tb_sprite_mover;

  logic       frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  // u1: default parameters; u2: SPEED_DIV = 3
  logic       rst1, play1, rst2, play2;
  logic [7:0] key1, key2;
  logic [3:0] wall1, wall2;
  logic [9:0] x1, y1, s1, x2, y2, s2;
  logic [1:0] side1, side2;
  logic       mov1, pend1, mov2, pend2;

  sprite_mover u1 (
    .frame_clk(frame_clk), .Reset_n(rst1), .playon(play1), .keycode(key1), .wall_free(wall1),
    .BallX(x1), .BallY(y1), .BallS(s1), .whichside(side1), .moving(mov1), .turn_pending(pend1));

  sprite_mover #(.SPEED_DIV(3)) u2 (
    .frame_clk(frame_clk), .Reset_n(rst2), .playon(play2), .keycode(key2), .wall_free(wall2),
    .BallX(x2), .BallY(y2), .BallS(s2), .whichside(side2), .moving(mov2), .turn_pending(pend2));

  typedef struct {
    logic       rst, play;
    logic [7:0] key;
    logic [3:0] wall;
    logic [9:0] x, y;
    logic [1:0] s;
    logic       m, p;
  } vec_t;

  localparam int NV = 21;
  vec_t tv[NV];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(logic rst, logic play, logic [7:0] key, logic [9:0] x,
                              logic [9:0] y, logic [1:0] s, logic m, logic p);
    vec_t v;
    v.rst = rst; v.play = play; v.key = key; v.wall = 4'hF;
    v.x = x; v.y = y; v.s = s; v.m = m; v.p = p;
    return v;
  endfunction

  task automatic step();
    @(posedge frame_clk);
    #1;
  endtask

  // Fields packed as {x, y, side, moving, pending}.
  task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got x=%0d y=%0d side=%0d mov=%0d pend=%0d, want x=%0d y=%0d side=%0d mov=%0d pend=%0d",
               nm, act[23:14], act[13:4], act[3:2], act[1], act[0],
               exp[23:14], exp[13:4], exp[3:2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [23:0] o1();
    return {x1, y1, side1, mov1, pend1};
  endfunction

  function automatic logic [23:0] o2();
    return {x2, y2, side2, mov2, pend2};
  endfunction

  initial begin
    rst1 = 1'b0; play1 = 1'b0; key1 = 8'h00; wall1 = 4'hF;
    rst2 = 1'b0; play2 = 1'b0; key2 = 8'h00; wall2 = 4'hF;

    // reset, start right, queued up-turn taken at grid point, reversal,
    // mid-move reset, turn from standstill, invalid key ignored
    tv[0]  = mk(0, 0, 8'h00, 310, 260, 0, 0, 0);
    tv[1]  = mk(1, 1, 8'h00, 310, 260, 0, 0, 0);
    tv[2]  = mk(1, 1, 8'h07, 311, 260, 1, 1, 0);
    tv[3]  = mk(1, 1, 8'h00, 312, 260, 1, 1, 0);
    tv[4]  = mk(1, 1, 8'h00, 313, 260, 1, 1, 0);
    tv[5]  = mk(1, 1, 8'h1A, 314, 260, 1, 1, 1);
    tv[6]  = mk(1, 1, 8'h00, 315, 260, 1, 1, 1);
    tv[7]  = mk(1, 1, 8'h00, 316, 260, 1, 1, 1);
    tv[8]  = mk(1, 1, 8'h00, 317, 260, 1, 1, 1);
    tv[9]  = mk(1, 1, 8'h00, 318, 260, 1, 1, 1);
    tv[10] = mk(1, 1, 8'h00, 319, 260, 1, 1, 1);
    tv[11] = mk(1, 1, 8'h00, 320, 260, 1, 1, 1);
    tv[12] = mk(1, 1, 8'h00, 320, 259, 3, 1, 0);
    tv[13] = mk(1, 1, 8'h00, 320, 258, 3, 1, 0);
    tv[14] = mk(1, 1, 8'h16, 320, 259, 2, 1, 0);
    tv[15] = mk(1, 1, 8'h00, 320, 260, 2, 1, 0);
    tv[16] = mk(1, 1, 8'h00, 320, 261, 2, 1, 0);
    tv[17] = mk(0, 1, 8'h1A, 310, 260, 0, 0, 0);
    tv[18] = mk(1, 1, 8'h00, 310, 260, 0, 0, 0);
    tv[19] = mk(1, 1, 8'h1A, 310, 259, 3, 1, 0);
    tv[20] = mk(1, 1, 8'h05, 310, 258, 3, 1, 0);

    for (int i = 0; i < NV; i++) begin
      rst1 = tv[i].rst; play1 = tv[i].play; key1 = tv[i].key; wall1 = tv[i].wall;
      step();
      chk($sformatf("vec%0d", i), o1(), {tv[i].x, tv[i].y, tv[i].s, tv[i].m, tv[i].p});
    end

    checks++;
    if (s1 !== 10'd4) begin
      errors++;
      $display("FAIL BallS: got %0d want 4", s1);
    end

    // wall closes at a grid point, then reopens with the key held
    rst1 = 1'b0; key1 = 8'h00; step();
    rst1 = 1'b1; step();
    key1 = 8'h07; step();
    chk("wall_start", o1(), {10'd311, 10'd260, 2'd1, 1'b1, 1'b0});
    key1 = 8'h00;
    repeat (9) step();
    chk("wall_at320", o1(), {10'd320, 10'd260, 2'd1, 1'b1, 1'b0});
    wall1 = 4'b1101; step();
    chk("wall_block", o1(), {10'd320, 10'd260, 2'd1, 1'b0, 1'b0});
    step();
    chk("wall_hold", o1(), {10'd320, 10'd260, 2'd1, 1'b0, 1'b0});
    wall1 = 4'hF; key1 = 8'h07; step();
    chk("wall_reopen", o1(), {10'd321, 10'd260, 2'd1, 1'b1, 1'b0});

    // run into the right playfield bound, then drop playon
    key1 = 8'h00;
    repeat (265) step();
    chk("bound_reach", o1(), {10'd586, 10'd260, 2'd1, 1'b1, 1'b0});
    step();
    chk("bound_stop", o1(), {10'd586, 10'd260, 2'd1, 1'b0, 1'b0});
    key1 = 8'h07; step();
    chk("bound_pend", o1(), {10'd586, 10'd260, 2'd1, 1'b0, 1'b1});
    key1 = 8'h00; play1 = 1'b0; step();
    chk("playoff", o1(), {10'd310, 10'd260, 2'd0, 1'b0, 1'b0});
    step();
    chk("hold", o1(), {10'd310, 10'd260, 2'd0, 1'b0, 1'b0});

    // SPEED_DIV = 3: moves only on every third edge, keys load every edge
    rst2 = 1'b0; step();
    chk("div_reset", o2(), {10'd310, 10'd260, 2'd0, 1'b0, 1'b0});
    rst2 = 1'b1; play2 = 1'b1; step();
    chk("div_start", o2(), {10'd310, 10'd260, 2'd0, 1'b0, 1'b0});
    key2 = 8'h1A; step();
    chk("div_load0", o2(), {10'd310, 10'd260, 2'd0, 1'b0, 1'b1});
    key2 = 8'h00; step();
    chk("div_wait1", o2(), {10'd310, 10'd260, 2'd0, 1'b0, 1'b1});
    step();
    chk("div_tick1", o2(), {10'd310, 10'd259, 2'd3, 1'b1, 1'b0});
    key2 = 8'h16; step();
    chk("div_load1", o2(), {10'd310, 10'd259, 2'd3, 1'b1, 1'b1});
    key2 = 8'h00; step();
    chk("div_wait2", o2(), {10'd310, 10'd259, 2'd3, 1'b1, 1'b1});
    step();
    chk("div_tick2", o2(), {10'd310, 10'd260, 2'd2, 1'b1, 1'b0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
